// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client and memory port signals of the memory port arbiter
interface mem_port_arbiter_if;
  logic        d_read;
  logic [3:0]  d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        m_read;
  logic [3:0]  m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  d_read, d_write, d_addr, d_wdata, i_read, i_addr, m_rdata, m_ready,
    output d_rdata, d_ready, i_rdata, i_ready, m_read, m_write, m_addr, m_wdata
  );

  modport master (
    output d_read, d_write, d_addr, d_wdata, i_read, i_addr, m_rdata, m_ready,
    input  d_rdata, d_ready, i_rdata, i_ready, m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the fetch and data clients
module mem_port_arbiter #(
  parameter int D_PRIORITY = 1,
  parameter int TIMEOUT    = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        owner,
  output logic              err_timeout
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_D = 2'd1, SERVE_I = 2'd2} state_t;

  localparam bit             WD_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TIMEOUT - 1 : 0);

  state_t            state, state_nx;
  logic              last_d;
  logic              lat_read;
  logic [3:0]        lat_write;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [CNT_W-1:0]  wd_cnt;
  logic              dreq, ireq, serving, wd_hit;
  logic              grant_d, grant_i, timed_out;

  assign dreq    = bus.d_read | (|bus.d_write);
  assign ireq    = bus.i_read;
  assign serving = (state != IDLE);
  assign wd_hit  = WD_EN && serving && (wd_cnt == WD_LAST);

  always_comb begin
    state_nx    = state;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    timed_out   = 1'b0;
    bus.d_ready = 1'b0;
    bus.d_rdata = '0;
    bus.i_ready = 1'b0;
    bus.i_rdata = '0;
    case (state)
      IDLE: begin
        // On a tie the data client wins unless round-robin says fetch is due
        if (dreq && (!ireq || D_PRIORITY != 0 || !last_d)) begin
          grant_d  = 1'b1;
          state_nx = SERVE_D;
        end else if (ireq) begin
          grant_i  = 1'b1;
          state_nx = SERVE_I;
        end
      end
      SERVE_D: begin
        if (bus.m_ready || wd_hit) begin
          bus.d_ready = 1'b1;
          bus.d_rdata = bus.m_ready ? bus.m_rdata : '0;
          timed_out   = !bus.m_ready;
          state_nx    = IDLE;
        end
      end
      SERVE_I: begin
        if (bus.m_ready || wd_hit) begin
          bus.i_ready = 1'b1;
          bus.i_rdata = bus.m_ready ? bus.m_rdata : '0;
          timed_out   = !bus.m_ready;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.m_read  = serving & lat_read;
  assign bus.m_write = serving ? lat_write : '0;
  assign bus.m_addr  = serving ? lat_addr : '0;
  assign bus.m_wdata = serving ? lat_wdata : '0;
  assign owner       = {state == SERVE_D, state == SERVE_I};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      lat_read    <= 1'b0;
      lat_write   <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (timed_out) err_timeout <= 1'b1;
      if (grant_d) begin
        // A write request overrides a simultaneous read request
        last_d    <= 1'b1;
        lat_read  <= bus.d_read & ~(|bus.d_write);
        lat_write <= bus.d_write;
        lat_addr  <= bus.d_addr & ~32'h3;
        lat_wdata <= bus.d_wdata;
        wd_cnt    <= '0;
      end else if (grant_i) begin
        last_d    <= 1'b0;
        lat_read  <= 1'b1;
        lat_write <= '0;
        lat_addr  <= bus.i_addr & ~32'h3;
        lat_wdata <= '0;
        wd_cnt    <= '0;
      end else if (serving) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if bus_a();
  mem_port_arbiter_if bus_b();
  logic [1:0] owner_a, owner_b;
  logic       err_a, err_b;

  mem_port_arbiter #(.D_PRIORITY(1), .TIMEOUT(4), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .owner(owner_a), .err_timeout(err_a));
  mem_port_arbiter #(.D_PRIORITY(0), .TIMEOUT(0), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .owner(owner_b), .err_timeout(err_b));

  typedef struct {
    logic [1:0]  own;
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;
  typedef struct {
    logic [1:0]  own;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  cmd_t       cmd_q[$];
  rsp_t       rsp_q[$];
  logic [1:0] grant_q_b[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         lat_a = 2;
  int         grants_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic void exp_cmd(input logic [1:0] own, input logic rd, input logic [3:0] wr,
                                  input logic [31:0] addr, input logic [31:0] wdata);
    cmd_q.push_back('{own: own, rd: rd, wr: wr, addr: addr, wdata: wdata});
  endfunction

  function automatic void exp_rsp(input logic [1:0] own, input logic [31:0] rdata, input int cyc);
    rsp_q.push_back('{own: own, rdata: rdata, cyc: cyc});
  endfunction

  // Memory model for A: ready after lat_a cycles of a held command, 0 = never
  initial begin : mem_a
    int cnt;
    cnt = 0;
    bus_a.m_ready = 1'b0;
    bus_a.m_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (bus_a.m_read || bus_a.m_write != 4'b0000) cnt++;
      else cnt = 0;
      if (lat_a != 0 && cnt == lat_a) begin
        bus_a.m_ready = 1'b1;
        bus_a.m_rdata = bus_a.m_addr ^ 32'hC0DE_0000;
      end else begin
        bus_a.m_ready = 1'b0;
        bus_a.m_rdata = '0;
      end
    end
  end

  initial begin : mem_b
    forever begin
      @(posedge clock); #1;
      bus_b.m_ready = bus_b.m_read || bus_b.m_write != 4'b0000;
      bus_b.m_rdata = bus_b.m_addr;
    end
  end

  initial begin : mon_a
    logic [1:0]  prev;
    int          serve;
    cmd_t        c;
    rsp_t        r;
    logic [6:0]  h_ctl;
    logic [31:0] h_addr, h_wdata;
    prev = 2'b00;
    serve = 0;
    h_ctl = '0;
    h_addr = '0;
    h_wdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 2'b00;
        serve = 0;
      end else begin
        if (owner_a != 2'b00) begin
          if (prev == 2'b00) begin
            serve = 1;
            if (cmd_q.size() == 0) check("grant_unexpected", 32'(owner_a), 32'd0);
            else begin
              c = cmd_q.pop_front();
              check("cmd_ctl", 32'({owner_a, bus_a.m_read, bus_a.m_write}), 32'({c.own, c.rd, c.wr}));
              check("cmd_addr", bus_a.m_addr, c.addr);
              check("cmd_wdata", bus_a.m_wdata, c.wdata);
            end
            h_ctl = {owner_a, bus_a.m_read, bus_a.m_write};
            h_addr = bus_a.m_addr;
            h_wdata = bus_a.m_wdata;
          end else begin
            serve++;
            check("cmd_hold_ctl", 32'({owner_a, bus_a.m_read, bus_a.m_write}), 32'(h_ctl));
            check("cmd_hold_addr", bus_a.m_addr, h_addr);
            check("cmd_hold_wdata", bus_a.m_wdata, h_wdata);
          end
          if (bus_a.d_ready || bus_a.i_ready) begin
            if (rsp_q.size() == 0)
              check("rsp_unexpected", 32'({bus_a.d_ready, bus_a.i_ready}), 32'd0);
            else begin
              r = rsp_q.pop_front();
              check("rsp_route", 32'({bus_a.d_ready, bus_a.i_ready}), 32'(r.own));
              check("rsp_rdata", r.own == 2'b10 ? bus_a.d_rdata : bus_a.i_rdata, r.rdata);
              check("rsp_other_rdata", r.own == 2'b10 ? bus_a.i_rdata : bus_a.d_rdata, 32'd0);
              check("rsp_cycle", serve, r.cyc);
            end
          end
        end else begin
          check("idle_quiet", 32'({bus_a.d_ready, bus_a.i_ready, bus_a.m_read, |bus_a.m_write}), 32'd0);
        end
        prev = owner_a;
      end
    end
  end

  initial begin : mon_b
    logic [1:0] prev;
    prev = 2'b00;
    forever begin
      @(negedge clock);
      if (reset) prev = 2'b00;
      else begin
        if (owner_b != 2'b00 && prev == 2'b00) begin
          grants_b++;
          if (grant_q_b.size() == 0) check("rr_grant_unexpected", 32'(owner_b), 32'd0);
          else check("rr_grant", 32'(owner_b), 32'(grant_q_b.pop_front()));
        end
        if (bus_b.d_ready || bus_b.i_ready)
          check("rr_ready_route", 32'({bus_b.d_ready, bus_b.i_ready}), 32'(owner_b));
        prev = owner_b;
      end
    end
  end

  task automatic wait_ready_a(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = bus_a.d_ready || bus_a.i_ready;
    end
    check(name, 32'(seen), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic wait_owner_a(input logic [1:0] want, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = (owner_a == want);
    end
    check(name, 32'(seen), 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required finish");
    $fatal(1);
  end

  initial begin : stim
    bus_a.d_read = 0; bus_a.d_write = 0; bus_a.d_addr = 0; bus_a.d_wdata = 0;
    bus_a.i_read = 0; bus_a.i_addr = 0;
    bus_b.d_read = 0; bus_b.d_write = 0; bus_b.d_addr = 0; bus_b.d_wdata = 0;
    bus_b.i_read = 0; bus_b.i_addr = 0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ready_rdata", 32'({bus_a.d_ready, bus_a.i_ready}) | bus_a.d_rdata | bus_a.i_rdata, 32'd0);
    check("reset_mcmd", 32'({bus_a.m_read, bus_a.m_write, owner_a, err_a}), 32'd0);
    check("reset_maddr_wdata", bus_a.m_addr | bus_a.m_wdata, 32'd0);
    @(posedge clock); #1;
    reset = 0;

    // T1: data read, memory answers in the second command cycle
    lat_a = 2;
    exp_cmd(2'b10, 1'b1, 4'b0000, 32'h0000_0100, 32'h0);
    exp_rsp(2'b10, 32'hC0DE_0100, 2);
    bus_a.d_addr = 32'h100; bus_a.d_read = 1;
    wait_ready_a("t1_wait");
    bus_a.d_read = 0;

    // T2: byte write with unaligned address
    exp_cmd(2'b10, 1'b0, 4'b0011, 32'h0000_0200, 32'hAABB_CCDD);
    exp_rsp(2'b10, 32'hC0DE_0200, 2);
    bus_a.d_addr = 32'h203; bus_a.d_wdata = 32'hAABB_CCDD; bus_a.d_write = 4'b0011;
    wait_ready_a("t2_wait");
    bus_a.d_write = 0;

    // Read together with write: write wins
    exp_cmd(2'b10, 1'b0, 4'b1000, 32'h0000_0304, 32'h1122_3344);
    exp_rsp(2'b10, 32'hC0DE_0304, 2);
    bus_a.d_addr = 32'h304; bus_a.d_wdata = 32'h1122_3344; bus_a.d_write = 4'b1000; bus_a.d_read = 1;
    wait_ready_a("t2b_wait");
    bus_a.d_write = 0; bus_a.d_read = 0; bus_a.d_wdata = 0;

    // T3: tie with data priority, fetch follows after a bubble
    exp_cmd(2'b10, 1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    exp_cmd(2'b01, 1'b1, 4'b0000, 32'h0000_0020, 32'h0);
    exp_rsp(2'b10, 32'hC0DE_0010, 2);
    exp_rsp(2'b01, 32'hC0DE_0020, 2);
    bus_a.d_addr = 32'h10; bus_a.i_addr = 32'h22; bus_a.d_read = 1; bus_a.i_read = 1;
    wait_ready_a("t3_wait_d");
    bus_a.d_read = 0;
    wait_ready_a("t3_wait_i");
    bus_a.i_read = 0;

    // T6: fetch drops its request after grant
    lat_a = 3;
    exp_cmd(2'b01, 1'b1, 4'b0000, 32'h0000_0604, 32'h0);
    exp_rsp(2'b01, 32'hC0DE_0604, 3);
    bus_a.i_addr = 32'h604; bus_a.i_read = 1;
    wait_owner_a(2'b01, "t6_wait_grant");
    bus_a.i_read = 0;
    wait_ready_a("t6_wait");
    repeat (3) @(posedge clock);

    // m_ready in the watchdog cycle completes normally
    lat_a = 4;
    exp_cmd(2'b10, 1'b1, 4'b0000, 32'h0000_0500, 32'h0);
    exp_rsp(2'b10, 32'hC0DE_0500, 4);
    bus_a.d_addr = 32'h500; bus_a.d_read = 1;
    wait_ready_a("tb_wait");
    bus_a.d_read = 0;
    @(negedge clock);
    check("boundary_no_err", 32'(err_a), 32'd0);

    // T4: memory never answers, watchdog aborts the fetch
    lat_a = 0;
    exp_cmd(2'b01, 1'b1, 4'b0000, 32'h0000_0400, 32'h0);
    exp_rsp(2'b01, 32'h0, 4);
    @(posedge clock); #1;
    bus_a.i_addr = 32'h400; bus_a.i_read = 1;
    wait_ready_a("t4_wait");
    bus_a.i_read = 0;
    @(negedge clock);
    check("t4_err_set", 32'(err_a), 32'd1);
    repeat (5) @(negedge clock);
    check("t4_err_sticky", 32'(err_a), 32'd1);

    // T5: reset in the middle of a data read
    exp_cmd(2'b10, 1'b1, 4'b0000, 32'h0000_0700, 32'h0);
    @(posedge clock); #1;
    bus_a.d_addr = 32'h700; bus_a.d_read = 1;
    wait_owner_a(2'b10, "t5_wait_grant");
    reset = 1; bus_a.d_read = 0;
    @(posedge clock); #1;
    check("t5_reset_cmd", 32'({bus_a.m_read, bus_a.m_write, owner_a}), 32'd0);
    check("t5_err_cleared", 32'(err_a), 32'd0);
    reset = 0;
    @(posedge clock); #2;
    bus_a.m_ready = 1; bus_a.m_rdata = 32'h1234_5678;
    @(negedge clock);
    check("t5_stray_ready", 32'({bus_a.d_ready, bus_a.i_ready}), 32'd0);
    repeat (3) @(posedge clock);
    check("queues_drained_a", 32'(cmd_q.size() + rsp_q.size()), 32'd0);

    // Round-robin instance: both requests held, grants alternate D,I,D,I
    grant_q_b.push_back(2'b10);
    grant_q_b.push_back(2'b01);
    grant_q_b.push_back(2'b10);
    grant_q_b.push_back(2'b01);
    @(posedge clock); #1;
    bus_b.d_addr = 32'h800; bus_b.i_addr = 32'h900; bus_b.d_read = 1; bus_b.i_read = 1;
    for (int k = 0; k < 40 && grants_b < 4; k++) begin
      @(negedge clock); #1;
    end
    check("rr_grants_reached", grants_b, 32'd4);
    @(posedge clock); #1;
    bus_b.d_read = 0; bus_b.i_read = 0;
    repeat (4) @(posedge clock);
    check("rr_grant_total", grants_b, 32'd4);
    check("rr_no_err", 32'(err_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
